// File: rtl/round_robin_demux_if.sv
// TDM receive-side bundle: incoming slot stream plus per-channel outputs and link status.
interface round_robin_demux_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MUX_DEPTH  = 2
);
    logic [DATA_WIDTH-1:0] tdm_data;
    logic                  tdm_valid;
    logic                  frame_sync;
    logic [DATA_WIDTH-1:0] channel_data [0:MUX_DEPTH-1];
    logic [MUX_DEPTH-1:0]  channel_valid;
    logic                  frame_done;
    logic                  locked;
    logic                  sync_err;

    modport master (
        output tdm_data, tdm_valid, frame_sync,
        input  channel_data, channel_valid, frame_done, locked, sync_err
    );

    modport slave (
        input  tdm_data, tdm_valid, frame_sync,
        output channel_data, channel_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/round_robin_demux.sv
// Round-robin TDM demultiplexer: aligns on frame_sync and scatters slot words to channel registers.
// Optional RR_DEMUX_FRAME_BUFFER_EN: buffer a whole frame in shadow registers and publish it atomically.
module round_robin_demux #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MUX_DEPTH  = 2
) (
    input logic               clk,
    input logic               rst,
    round_robin_demux_if.slave bus
);
    localparam int unsigned       SLOT_W    = (MUX_DEPTH > 1) ? $clog2(MUX_DEPTH) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MUX_DEPTH - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d, wr_slot;
    logic                  wr_en;
    logic                  done_d, err_d;
    logic [MUX_DEPTH-1:0]  valid_d, valid_q;
    logic                  done_q, err_q, locked_q;
    logic [DATA_WIDTH-1:0] data_q [0:MUX_DEPTH-1];

    // Next-state, slot write decode and status strobes
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        wr_slot = slot_q;
        err_d   = 1'b0;
        valid_d = '0;

        if (bus.tdm_valid) begin
            if (bus.frame_sync) begin
                // A sync beat always realigns to slot 0; mid-frame it is an error
                wr_en   = 1'b1;
                wr_slot = '0;
                err_d   = (state_q == LOCKED) && (slot_q != '0);
                state_d = LOCKED;
            end else if (state_q == LOCKED) begin
                if (slot_q != '0) begin
                    wr_en = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = UNLOCKED;
                end
            end
        end

        if (wr_en) begin
            slot_d = (wr_slot == LAST_SLOT) ? '0 : wr_slot + SLOT_W'(1);
        end

        done_d = wr_en && (wr_slot == LAST_SLOT);

`ifdef RR_DEMUX_FRAME_BUFFER_EN
        valid_d = {MUX_DEPTH{done_d}};
`else
        for (int unsigned k = 0; k < MUX_DEPTH; k++) begin
            valid_d[k] = wr_en && (wr_slot == SLOT_W'(k));
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNLOCKED;
            slot_q   <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
        end
    end

`ifdef RR_DEMUX_FRAME_BUFFER_EN
    logic [DATA_WIDTH-1:0] shadow_q [0:MUX_DEPTH-1];

    // Collect slots in shadow; the last slot bypasses shadow straight to the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < MUX_DEPTH; k++) begin
                shadow_q[k] <= '0;
                data_q[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < MUX_DEPTH; k++) begin
                if (wr_en && (wr_slot == SLOT_W'(k))) begin
                    shadow_q[k] <= bus.tdm_data;
                end
                if (done_d) begin
                    data_q[k] <= (k == MUX_DEPTH - 1) ? bus.tdm_data : shadow_q[k];
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < MUX_DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < MUX_DEPTH; k++) begin
                if (valid_d[k]) begin
                    data_q[k] <= bus.tdm_data;
                end
            end
        end
    end
`endif

    assign bus.channel_data  = data_q;
    assign bus.channel_valid = valid_q;
    assign bus.frame_done    = done_q;
    assign bus.locked        = locked_q;
    assign bus.sync_err      = err_q;
endmodule

// File: doc/round_robin_demux.md
Name: round_robin_demux

Overview:
- Receive-side counterpart of the round-robin TDM mux.
- Accepts a time-division-multiplexed word stream, one slot per valid beat, and scatters each word to its per-channel output register.
- A frame_sync marker on slot 0 aligns the slot counter. Lock/error status lets downstream logic discard misaligned frames.
- Sits at the far end of the TDM link, feeding per-channel consumers.

Parameters:
- DATA_WIDTH, 8: width of each TDM word and each channel output.
- MUX_DEPTH, 2: number of channels (slots) per frame, >= 1; must match the transmit mux.
- SLOT_W, $clog2(MUX_DEPTH) (minimum 1): slot counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- tdm_data  input  DATA_WIDTH  incoming TDM word.
- tdm_valid  input  1  tdm_data is a slot beat this cycle; tie high for a free-running link.
- frame_sync  input  1  qualified by tdm_valid; marks the beat as slot 0.
- channel_data  output  DATA_WIDTH x MUX_DEPTH (unpacked [0:MUX_DEPTH-1])  per-channel registered word.
- channel_valid  output  MUX_DEPTH  one-cycle strobe per channel when its channel_data updates.
- frame_done  output  1  one-cycle pulse, full frame (slots 0..MUX_DEPTH-1) received in order.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on any alignment violation.

Behaviour:
- Reset (async assert, sync release behaviour irrelevant): state=UNLOCKED, slot=0. channel_data all 0, channel_valid 0, frame_done 0, locked 0, sync_err 0. Reset mid-frame discards the partial frame.
- FSM states: UNLOCKED, LOCKED.
- UNLOCKED:
  - Beats with !frame_sync are dropped, no outputs.
  - On tdm_valid && frame_sync: write channel 0, slot<=1 (or 0 if MUX_DEPTH==1), go LOCKED.
- LOCKED, tdm_valid && !frame_sync && slot!=0: write channel[slot], advance slot.
- LOCKED, tdm_valid && frame_sync && slot==0: normal slot 0, write channel 0.
- LOCKED, tdm_valid && frame_sync && slot!=0 (early sync):
  - sync_err pulse.
  - Beat treated as slot 0: write channel 0, slot<=1.
  - Stay LOCKED; no frame_done for the truncated frame.
- LOCKED, tdm_valid && !frame_sync && slot==0 (missing sync):
  - sync_err pulse, beat dropped, go UNLOCKED, locked deasserts next cycle.
- !tdm_valid: slot and state hold (stall); no strobes.
- Slot wrap: after slot MUX_DEPTH-1 is written, slot<=0; frame_done pulses the cycle after that beat.
- Latency: channel_data[k] and channel_valid[k] are registered, visible 1 cycle after the accepting clk edge. channel_data holds its value until the next write.
- MUX_DEPTH==1: every valid beat must carry frame_sync. Each accepted beat gives channel_valid[0] and frame_done together.
- Simultaneous events:
  - Early-sync realign and the channel 0 write happen in the same cycle.
  - sync_err and frame_done never assert together.

Optional Feature:
- Macro: RR_DEMUX_FRAME_BUFFER_EN.
- Defined:
  - Slot writes go to internal shadow registers.
  - On frame completion, all channel_data update simultaneously from the shadow, all channel_valid bits assert for one cycle, coincident with frame_done.
  - Partial frames (early sync, missing sync, reset) never reach channel_data.
- Undefined: per-slot update as described in Behaviour; no shadow registers.

Test Plan:
- MUX_DEPTH=4, tdm_valid=1, frame_sync on 0xA0, followed by 0xA1, 0xA2, 0xA3 -> locked=1 after first beat; channel_data = {A0,A1,A2,A3}; channel_valid strobes 0001, 0010, 0100, 1000 on consecutive cycles; frame_done pulse 1 cycle after 0xA3.
- Locked, beats 0x10(sync), 0x11, then 0x20 with frame_sync -> sync_err pulse; channel_data[0]=0x20; next beat 0x21 -> channel_data[1]=0x21; no frame_done for the truncated frame.
- Locked, completed frame, next beat 0x55 without frame_sync -> sync_err pulse, locked=0, channel_data unchanged. Later 0x66 with sync -> relock, channel_data[0]=0x66.
- Alternate tdm_valid 1/0 through a 4-slot frame -> slots advance only on valid beats; frame_done after the 4th valid beat.
- Assert rst after slot 2 of a frame -> all outputs 0 immediately (async); after release, beats without sync are ignored until a frame_sync beat.
- With RR_DEMUX_FRAME_BUFFER_EN defined, repeat the first scenario -> channel_data stays 0 until frame_done, then all four update in one cycle with channel_valid=1111.
